// File: rtl/inst_rom_loader_pkg.sv
// Shared constants and types for the instruction ROM with byte-serial boot loader.
package inst_rom_loader_pkg;

    localparam int          RegBus              = 32;
    localparam int          InstAddrBus         = 32;
    localparam int          InstBus             = 32;
    localparam logic [31:0] ZeroWord            = 32'h0000_0000;
    localparam int          RomAddrWidthDefault = 10;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } ld_state_e;

    // Big-endian packing: byte index 0 lands in bits 31:24.
    function automatic logic [InstBus-1:0] place_byte(
        input logic [InstBus-1:0] acc,
        input logic [7:0]         b,
        input logic [1:0]         idx
    );
        logic [InstBus-1:0] w;
        case (idx)
            2'd0:    w = {b, 24'h000000};
            2'd1:    w = {8'h00, b, 16'h0000};
            2'd2:    w = {16'h0000, b, 8'h00};
            default: w = {24'h000000, b};
        endcase
        return acc | w;
    endfunction

endpackage

// File: rtl/inst_rom_loader_mem.sv
// Instruction word storage: one synchronous write port, one asynchronous read port.
module inst_mem_array
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = RomAddrWidthDefault
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [InstBus-1:0]    wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [InstBus-1:0]    rdata
);

    logic [InstBus-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Fetch responder plus boot loader: packs a byte stream into words, then releases the core.
// Loader handshake: a byte transfers on a rising edge where ld_valid_i and ld_ready_o are both high;
// ld_ready_o depends only on state, and ld_last_i/ld_byte_i are meaningful only on a transfer.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = RomAddrWidthDefault
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_ce_i,
    input  logic [InstAddrBus-1:0] rom_addr_i,
    output logic [InstBus-1:0]     rom_data_o,
    input  logic                   ld_valid_i,
    output logic                   ld_ready_o,
    input  logic [7:0]             ld_byte_i,
    input  logic                   ld_last_i,
    input  logic                   ld_restart_i,
    output logic                   cpu_rst_o,
    output logic [ADDR_WIDTH:0]    words_o,
    output logic                   err_o
);

    ld_state_e             r_state;
    ld_state_e             w_state_next;
    logic [1:0]            r_byte_cnt;
    logic [InstBus-1:0]    r_asm;
    logic [ADDR_WIDTH:0]   r_wptr;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_word_done;
    logic                  w_full;
    logic                  w_we;
    logic                  w_restart;
    logic [InstBus-1:0]    w_word;
    logic [InstBus-1:0]    w_rdata;
    logic                  w_addr_in_range;
    logic                  w_unused_addr_lsb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ld_ready_o   = 1'b0;
        cpu_rst_o    = 1'b1;
        case (r_state)
            ST_BOOT: begin
                ld_ready_o = 1'b1;
                if (ld_valid_i && ld_last_i) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                cpu_rst_o = 1'b0;
                if (ld_restart_i) begin
                    w_state_next = ST_BOOT;
                end
            end
            default: w_state_next = ST_BOOT;
        endcase
    end

    assign w_accept    = ld_valid_i & ld_ready_o;
    assign w_restart   = (r_state == ST_RUN) & ld_restart_i;
    assign w_word      = place_byte(r_asm, ld_byte_i, r_byte_cnt);
    assign w_word_done = w_accept & ((r_byte_cnt == 2'd3) | ld_last_i);
    // wptr parks at the array depth once full; its top bit is the "array full" flag.
    assign w_full      = r_wptr[ADDR_WIDTH];
    assign w_we        = w_word_done & ~w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= 2'd0;
            r_asm      <= ZeroWord;
            r_wptr     <= '0;
            r_err      <= 1'b0;
        end else if (w_restart) begin
            r_byte_cnt <= 2'd0;
            r_asm      <= ZeroWord;
            r_wptr     <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            if (w_word_done) begin
                r_byte_cnt <= 2'd0;
                r_asm      <= ZeroWord;
                if (w_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_wptr <= r_wptr + 1'b1;
                end
            end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_asm      <= w_word;
            end
        end
    end

    inst_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wptr[ADDR_WIDTH-1:0]),
        .wdata (w_word),
        .raddr (rom_addr_i[ADDR_WIDTH+1:2]),
        .rdata (w_rdata)
    );

    assign w_addr_in_range   = ~|rom_addr_i[InstAddrBus-1:ADDR_WIDTH+2];
    assign w_unused_addr_lsb = ^rom_addr_i[1:0];

    assign rom_data_o = (rom_ce_i && (r_state == ST_RUN) && w_addr_in_range) ? w_rdata : ZeroWord;
    assign words_o    = r_wptr;
    assign err_o      = r_err;

endmodule
